// File: rtl/placement_pkg.sv
// Shared widths, types and helpers for the placement request scheduler.
package placement_pkg;

  localparam int DIM_W       = 5;
  localparam int IDX_W       = 8;
  localparam int SLOT_CYCLES = 4;
  localparam int ID_W        = 2;

  localparam int REQ_W   = 2 * DIM_W;
  localparam int MAX_REQ = 1 << ID_W;
  localparam int PH_W    = $clog2(SLOT_CYCLES);

  typedef enum logic [PH_W-1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  typedef struct packed {
    logic [DIM_W-1:0] height;
    logic [DIM_W-1:0] width;
  } req_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // A request with either dimension zero has nothing to place.
  function automatic logic is_zero_size(input req_t r);
    return (r.height == '0) || (r.width == '0);
  endfunction

endpackage

// File: rtl/placement_req_fifo.sv
// Per-requester request FIFO; full/empty come from the registered count only.
module placement_req_fifo
  import placement_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [REQ_W-1:0] din,
  output logic [REQ_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Occupancy after this cycle's push/pop.
  always_comb count_d = count_q + CW'(do_push) - CW'(do_pop);

  // Pointer and count registers.
  // NOTE: clocked state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage array written on push.
  // NOTE: the data array has no reset; the count guards every read, so stale contents are never used.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/placement_req_scheduler.sv
// Round-robin sharing of one placement core between N_REQ sources, one request per 4-cycle slot.
module placement_req_scheduler
  import placement_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int CORE_LAT   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [DIM_W*N_REQ-1:0] req_height_i,
  input  logic [DIM_W*N_REQ-1:0] req_width_i,
  output logic [DIM_W-1:0]       core_height_o,
  output logic [DIM_W-1:0]       core_width_o,
  input  logic [IDX_W-1:0]       core_index_x_i,
  input  logic [IDX_W-1:0]       core_index_y_i,
  output logic                   rsp_valid_o,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [IDX_W-1:0]       rsp_index_x_o,
  output logic [IDX_W-1:0]       rsp_index_y_o,
  output logic                   illegal_o,
  output logic                   busy_o
);

  localparam int CW = ID_W + 1;

  phase_e          phase_q, phase_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  req_t            core_q, core_d;
  logic            issued_q, issued_d;
  logic [ID_W-1:0] issue_id_q, issue_id_d;
  logic            illegal_q;
  tag_t            tag_q [CORE_LAT];
  tag_t            tag_in, tag_out;
  logic [ID_W-1:0] rsp_id_q;
  logic [IDX_W-1:0] rsp_x_q, rsp_y_q;

  logic [MAX_REQ-1:0] fifo_empty;
  req_t               fifo_head [MAX_REQ];
  logic [N_REQ-1:0]   illegal_req;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [CW-1:0]      cand;
  logic               any_tag;

  // Unused requester slots look permanently empty so the arbiter can index a full power-of-two table.
  for (genvar k = 0; k < MAX_REQ; k++) begin : g_req
    if (k < N_REQ) begin : g_fifo
      req_t in_req;
      logic full, store, pop;
      assign in_req.height  = req_height_i[DIM_W*k +: DIM_W];
      assign in_req.width   = req_width_i[DIM_W*k +: DIM_W];
      assign req_ready_o[k] = !full;
      assign store          = req_valid_i[k] && !full && !is_zero_size(in_req);
      assign illegal_req[k] = req_valid_i[k] && !full && is_zero_size(in_req);
      assign pop            = (phase_q == PH3) && win_valid && (win_id == ID_W'(k));

      placement_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (store),
        .pop   (pop),
        .din   (in_req),
        .dout  (fifo_head[k]),
        .full  (full),
        .empty (fifo_empty[k])
      );
    end else begin : g_tie
      assign fifo_empty[k] = 1'b1;
      assign fifo_head[k]  = '0;
    end
  end

  // Round-robin pick: first non-empty FIFO starting after the last grant.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, last_grant_q} + CW'(1 + i);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!win_valid && !fifo_empty[cand[ID_W-1:0]]) begin
        win_valid = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  // Slot sequencing: the phase-3 decision loads the core inputs held for the whole next slot.
  always_comb begin
    phase_d      = phase_e'(phase_q + PH_W'(1));
    core_d       = core_q;
    issued_d     = issued_q;
    issue_id_d   = issue_id_q;
    last_grant_d = last_grant_q;
    if (phase_q == PH3) begin
      issued_d   = win_valid;
      issue_id_d = win_id;
      core_d     = win_valid ? fifo_head[win_id] : '0;
      if (win_valid) last_grant_d = win_id;
    end
  end

  // A slot's tag enters the pipe during its phase-0 cycle and reaches the last stage CORE_LAT cycles later.
  assign tag_in.valid = issued_q && (phase_q == PH0);
  assign tag_in.id    = issue_id_q;
  assign tag_out      = tag_q[CORE_LAT-1];

  // Any issued request still waiting for its result.
  always_comb begin
    any_tag = tag_in.valid;
    for (int i = 0; i < CORE_LAT; i++) any_tag = any_tag | tag_q[i].valid;
  end

  // Slot state, tag pipe and response hold registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q      <= PH0;
      last_grant_q <= ID_W'(N_REQ - 1);
      core_q       <= '0;
      issued_q     <= 1'b0;
      issue_id_q   <= '0;
      illegal_q    <= 1'b0;
      rsp_id_q     <= '0;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      for (int i = 0; i < CORE_LAT; i++) tag_q[i] <= '0;
    end else begin
      phase_q      <= phase_d;
      last_grant_q <= last_grant_d;
      core_q       <= core_d;
      issued_q     <= issued_d;
      issue_id_q   <= issue_id_d;
      illegal_q    <= |illegal_req;
      tag_q[0]     <= tag_in;
      for (int i = 1; i < CORE_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (tag_out.valid) begin
        rsp_id_q <= tag_out.id;
        rsp_x_q  <= core_index_x_i;
        rsp_y_q  <= core_index_y_i;
      end
    end
  end

  assign core_height_o = core_q.height;
  assign core_width_o  = core_q.width;
  assign illegal_o     = illegal_q;
  assign rsp_valid_o   = tag_out.valid;
  assign rsp_id_o      = tag_out.valid ? tag_out.id     : rsp_id_q;
  assign rsp_index_x_o = tag_out.valid ? core_index_x_i : rsp_x_q;
  assign rsp_index_y_o = tag_out.valid ? core_index_y_i : rsp_y_q;
  assign busy_o        = (fifo_empty[N_REQ-1:0] != {N_REQ{1'b1}}) || any_tag;

endmodule

// File: tb/tb_placement_req_scheduler.sv
// Directed bench for placement_req_scheduler with a delayed-result placement core model.
module tb_placement_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [9:0]  req_height_i, req_width_i;
  logic [4:0]  core_height_o, core_width_o;
  logic [7:0]  core_index_x_i, core_index_y_i;
  logic        rsp_valid_o;
  logic [1:0]  rsp_id_o;
  logic [7:0]  rsp_index_x_o, rsp_index_y_o;
  logic        illegal_o, busy_o;

  int errors = 0;
  int checks = 0;
  logic [1:0] ph = 2'd0;

  always #5 clk = ~clk;

  placement_req_scheduler dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_height_i   (req_height_i),
    .req_width_i    (req_width_i),
    .core_height_o  (core_height_o),
    .core_width_o   (core_width_o),
    .core_index_x_i (core_index_x_i),
    .core_index_y_i (core_index_y_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_id_o       (rsp_id_o),
    .rsp_index_x_o  (rsp_index_x_o),
    .rsp_index_y_o  (rsp_index_y_o),
    .illegal_o      (illegal_o),
    .busy_o         (busy_o)
  );

  // Core model: result for the inputs seen 8 cycles earlier; x = 3h + w, y = 5w + h.
  logic [4:0] dh [8] = '{default: 5'd0};
  logic [4:0] dw [8] = '{default: 5'd0};
  always @(posedge clk) begin
    dh[0] <= core_height_o;
    dw[0] <= core_width_o;
    for (int i = 1; i < 8; i++) begin
      dh[i] <= dh[i-1];
      dw[i] <= dw[i-1];
    end
  end
  assign core_index_x_i = {3'b0, dh[7]} * 8'd3 + {3'b0, dw[7]};
  assign core_index_y_i = {3'b0, dw[7]} * 8'd5 + {3'b0, dh[7]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ph = ph + 2'd1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [4:0] h, input logic [4:0] w);
    req_valid_i[k]        = v;
    req_height_i[5*k +: 5] = h;
    req_width_i[5*k +: 5]  = w;
  endtask

  // Expected grant sequence for the two-requester test.
  int eh  [4] = '{1, 9, 5, 11};
  int ew  [4] = '{2, 10, 6, 12};
  int eid [4] = '{0, 1, 0, 1};
  int ex  [4] = '{5, 37, 21, 45};
  int ey  [4] = '{11, 59, 35, 71};

  initial begin
    rst_i = 1'b1;
    req_valid_i = '0;
    req_height_i = '0;
    req_width_i = '0;

    // Reset state
    repeat (3) step();
    rst_i = 1'b0;
    ph = 2'd0;
    check("rst_core_h", core_height_o, 0);
    check("rst_core_w", core_width_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_id", rsp_id_o, 0);
    check("rst_rsp_x", rsp_index_x_o, 0);
    check("rst_rsp_y", rsp_index_y_o, 0);
    check("rst_illegal", illegal_o, 0);
    check("rst_ready", req_ready_o, 2'b11);
    check("rst_busy", busy_o, 0);

    // Single request (3,4) pushed at phase 1
    step();
    set_req(0, 1'b1, 5'd3, 5'd4);
    step();
    set_req(0, 1'b0, 5'd0, 5'd0);
    check("t1_busy_queued", busy_o, 1);
    check("t1_core_h_before", core_height_o, 0);
    step();
    step();
    for (int c = 0; c <= 8; c++) begin
      check("t1_core_h", core_height_o, (c < 4) ? 3 : 0);
      check("t1_core_w", core_width_o, (c < 4) ? 4 : 0);
      check("t1_rsp_valid", rsp_valid_o, (c == 8) ? 1 : 0);
      if (c == 8) begin
        check("t1_rsp_id", rsp_id_o, 0);
        check("t1_rsp_x", rsp_index_x_o, 13);
        check("t1_rsp_y", rsp_index_y_o, 23);
      end
      if (c < 8) step();
    end
    step();
    check("t1_rsp_valid_after", rsp_valid_o, 0);
    check("t1_rsp_x_hold", rsp_index_x_o, 13);
    check("t1_rsp_y_hold", rsp_index_y_o, 23);
    check("t1_busy_idle", busy_o, 0);

    // Two requesters with two entries each, plus an ignored third push to a full FIFO
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    ph = 2'd0;
    set_req(0, 1'b1, 5'd1, 5'd2);
    set_req(1, 1'b1, 5'd9, 5'd10);
    step();
    set_req(0, 1'b1, 5'd5, 5'd6);
    set_req(1, 1'b1, 5'd11, 5'd12);
    step();
    set_req(0, 1'b0, 5'd0, 5'd0);
    set_req(1, 1'b1, 5'd13, 5'd14);
    check("t2_ready_full_ph2", req_ready_o, 2'b00);
    step();
    check("t2_ready_full_ph3", req_ready_o, 2'b00);
    step();
    set_req(1, 1'b0, 5'd0, 5'd0);
    check("t2_ready_after_pop", req_ready_o, 2'b01);
    for (int c = 0; c <= 24; c++) begin
      if (c % 4 == 0) begin
        check("t2_core_h", core_height_o, (c < 16) ? eh[c/4] : 0);
        check("t2_core_w", core_width_o, (c < 16) ? ew[c/4] : 0);
      end
      if (c >= 8 && c <= 20 && (c % 4 == 0)) begin
        check("t2_rsp_valid", rsp_valid_o, 1);
        check("t2_rsp_id", rsp_id_o, eid[(c-8)/4]);
        check("t2_rsp_x", rsp_index_x_o, ex[(c-8)/4]);
        check("t2_rsp_y", rsp_index_y_o, ey[(c-8)/4]);
      end else begin
        check("t2_rsp_quiet", rsp_valid_o, 0);
      end
      step();
    end
    check("t2_busy_idle", busy_o, 0);

    // Zero-size requests from both requesters at phase 1: one illegal pulse, nothing stored
    set_req(0, 1'b1, 5'd0, 5'd7);
    set_req(1, 1'b1, 5'd5, 5'd0);
    step();
    set_req(0, 1'b0, 5'd0, 5'd0);
    set_req(1, 1'b0, 5'd0, 5'd0);
    check("t4_illegal_pulse", illegal_o, 1);
    check("t4_busy", busy_o, 0);
    check("t4_ready", req_ready_o, 2'b11);
    step();
    check("t4_illegal_single", illegal_o, 0);
    step();
    for (int c = 0; c < 12; c++) begin
      check("t4_core_h", core_height_o, 0);
      check("t4_core_w", core_width_o, 0);
      check("t4_rsp_quiet", rsp_valid_o, 0);
      check("t4_illegal_quiet", illegal_o, 0);
      check("t4_busy", busy_o, 0);
      step();
    end

    // Reset three cycles after an issue drops that request and restores requester-0 priority
    step();
    set_req(0, 1'b1, 5'd8, 5'd9);
    step();
    set_req(0, 1'b0, 5'd0, 5'd0);
    step();
    step();
    check("t6_core_h_issue", core_height_o, 8);
    check("t6_core_w_issue", core_width_o, 9);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t6_rsp_quiet_pre", rsp_valid_o, 0);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    ph = 2'd0;
    check("t6_rst_core_h", core_height_o, 0);
    check("t6_rst_core_w", core_width_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_ready", req_ready_o, 2'b11);
    check("t6_rst_rsp_valid", rsp_valid_o, 0);
    set_req(0, 1'b1, 5'd2, 5'd3);
    set_req(1, 1'b1, 5'd4, 5'd5);
    step();
    set_req(0, 1'b0, 5'd0, 5'd0);
    set_req(1, 1'b0, 5'd0, 5'd0);
    check("t6_rsp_quiet_ph1", rsp_valid_o, 0);
    step();
    check("t6_rsp_quiet_ph2", rsp_valid_o, 0);
    step();
    check("t6_rsp_quiet_ph3", rsp_valid_o, 0);
    step();
    for (int c = 0; c <= 12; c++) begin
      if (c % 4 == 0) begin
        check("t6_core_h", core_height_o, (c == 0) ? 2 : (c == 4) ? 4 : 0);
        check("t6_core_w", core_width_o, (c == 0) ? 3 : (c == 4) ? 5 : 0);
      end
      if (c == 8 || c == 12) begin
        check("t6_rsp_valid", rsp_valid_o, 1);
        check("t6_rsp_id", rsp_id_o, (c == 8) ? 0 : 1);
        check("t6_rsp_x", rsp_index_x_o, (c == 8) ? 9 : 17);
        check("t6_rsp_y", rsp_index_y_o, (c == 8) ? 17 : 29);
      end else begin
        check("t6_rsp_quiet", rsp_valid_o, 0);
      end
      step();
    end
    check("t6_busy_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
